// File: rtl/hex_keypad_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hex_keypad_pkg
//  Description : Shared types and constants for the 4x4 hex keypad scanner:
//                debounce state encoding, per-scan result encoding, the
//                {row,col} -> hex key map and default timing values.
//  Optional    : KEYPAD_AUTOREPEAT_EN (consumed by keypad_debounce)
//  Revision    : 1.0 - initial release
// ============================================================================
package hex_keypad_pkg;

    // Debounce FSM states (explicit 2-bit encoding).
    typedef enum logic [1:0] {
        DB_IDLE        = 2'd0,
        DB_PRESS_CHK   = 2'd1,
        DB_HELD        = 2'd2,
        DB_RELEASE_CHK = 2'd3
    } db_state_e;

    // Classification of one complete scan of the matrix.
    typedef enum logic [1:0] {
        SCAN_NONE   = 2'd0,
        SCAN_SINGLE = 2'd1,
        SCAN_MULTI  = 2'd2
    } scan_res_e;

    // Nibble i holds the legend of the key at index i = {row[1:0], col[1:0]}.
    //   r0: 1 2 3 A   r1: 4 5 6 B   r2: 7 8 9 C   r3: 0 F E D
    localparam logic [63:0] KEY_MAP = 64'hDEF0_C987_B654_A321;

    localparam int DEF_SETTLE_CYCLES  = 256;
    localparam int DEF_DEBOUNCE_SCANS = 4;
    localparam int DEF_REPEAT_DELAY   = 64;
    localparam int DEF_REPEAT_PERIOD  = 16;

    function automatic logic [3:0] key_lookup(input logic [3:0] idx);
        return KEY_MAP[{idx, 2'b00} +: 4];
    endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_debounce
//  Description : Per-scan debounce FSM. Accepts a press after DEBOUNCE_SCANS
//                identical single-key scans, a release after DEBOUNCE_SCANS
//                non-matching scans, and supports rollover to a new key.
//  Optional    : KEYPAD_AUTOREPEAT_EN - re-pulse key_valid_o while held,
//                first after REPEAT_DELAY scans then every REPEAT_PERIOD.
//  Ports       : clk, rst_n      clock / async active-low reset
//                strobe_i        one-cycle pulse: res_i/key_i are valid
//                res_i [1:0]     scan_res_e of the completed scan
//                key_i [3:0]     hex code when res_i == SCAN_SINGLE
//                key_valid_o     one-cycle pulse per accepted key event
//                key_code_o[3:0] code of the last accepted key
//                key_held_o      a debounced key is down
//  Revision    : 1.0 - initial release
// ============================================================================
module keypad_debounce
    import hex_keypad_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = DEF_DEBOUNCE_SCANS,
    parameter int REPEAT_DELAY   = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD  = DEF_REPEAT_PERIOD
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       strobe_i,
    input  logic [1:0] res_i,
    input  logic [3:0] key_i,
    output logic       key_valid_o,
    output logic [3:0] key_code_o,
    output logic       key_held_o
);

    localparam int            CW     = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CW-1:0] C_DMAX = CW'(DEBOUNCE_SCANS);
    localparam logic [CW-1:0] C_ONE  = CW'(1);

    db_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    cand_q, cand_d;
    logic [3:0]    code_q, code_d;
    logic          valid_q, held_q;
    logic          w_single, w_same, w_accept, w_stay_held, w_rpt_fire;
    logic [CW-1:0] w_cnt_inc;

    assign w_single  = (res_i == SCAN_SINGLE);
    assign w_same    = w_single && (key_i == cand_q);
    // Counter saturates so it can never wrap back below the threshold.
    assign w_cnt_inc = (cnt_q == C_DMAX) ? cnt_q : cnt_q + C_ONE;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cand_d      = cand_q;
        w_accept    = 1'b0;
        w_stay_held = 1'b0;
        if (strobe_i) begin
            case (state_q)
                DB_IDLE: begin
                    if (w_single) begin
                        state_d = DB_PRESS_CHK;
                        cand_d  = key_i;
                        cnt_d   = C_ONE;
                    end
                end
                DB_PRESS_CHK: begin
                    if (w_same) begin
                        cnt_d = w_cnt_inc;
                        if (w_cnt_inc == C_DMAX) begin
                            state_d  = DB_HELD;
                            w_accept = 1'b1;
                        end
                    end else if (w_single) begin
                        cand_d = key_i;
                        cnt_d  = C_ONE;
                    end else begin
                        state_d = DB_IDLE;
                    end
                end
                DB_HELD: begin
                    if (w_same) begin
                        w_stay_held = 1'b1;
                    end else begin
                        state_d = DB_RELEASE_CHK;
                        cnt_d   = C_ONE;
                    end
                end
                DB_RELEASE_CHK: begin
                    if (w_same) begin
                        state_d = DB_HELD;
                    end else if (w_single) begin
                        // Rollover: a new key starts its own confirmation.
                        state_d = DB_PRESS_CHK;
                        cand_d  = key_i;
                        cnt_d   = C_ONE;
                    end else begin
                        cnt_d = w_cnt_inc;
                        if (w_cnt_inc == C_DMAX) begin
                            state_d = DB_IDLE;
                        end
                    end
                end
                default: state_d = DB_IDLE;
            endcase
        end
    end

    assign code_d = w_accept ? cand_q : code_q;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);

    logic [RW-1:0] rpt_q;
    logic          rpt_first_q;   // first repeat already issued
    logic [RW-1:0] w_rpt_next, w_rpt_tgt;

    assign w_rpt_next = rpt_q + RW'(1);
    assign w_rpt_tgt  = rpt_first_q ? RW'(REPEAT_PERIOD) : RW'(REPEAT_DELAY);
    assign w_rpt_fire = w_stay_held && (w_rpt_next == w_rpt_tgt);

    // Counter only advances on held scans, so RELEASE_CHK freezes it and a
    // return to HELD resumes; IDLE / PRESS_CHK wipe it for the next press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_q       <= '0;
            rpt_first_q <= 1'b0;
        end else if ((state_d == DB_IDLE) || (state_d == DB_PRESS_CHK)) begin
            rpt_q       <= '0;
            rpt_first_q <= 1'b0;
        end else if (w_rpt_fire) begin
            rpt_q       <= '0;
            rpt_first_q <= 1'b1;
        end else if (w_stay_held) begin
            rpt_q       <= w_rpt_next;
        end
    end
`else
    logic w_unused_rpt;
    assign w_rpt_fire   = 1'b0;
    assign w_unused_rpt = w_stay_held ^ (REPEAT_DELAY > 0) ^ (REPEAT_PERIOD > 0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= DB_IDLE;
            cnt_q   <= '0;
            cand_q  <= 4'd0;
            code_q  <= 4'd0;
            valid_q <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cand_q  <= cand_d;
            code_q  <= code_d;
            valid_q <= w_accept | w_rpt_fire;
            held_q  <= (state_d == DB_HELD) || (state_d == DB_RELEASE_CHK);
        end
    end

    assign key_valid_o = valid_q;
    assign key_code_o  = code_q;
    assign key_held_o  = held_q;

endmodule
`default_nettype wire

// File: rtl/hex_keypad_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : hex_keypad_scanner
//  Description : 4x4 hex keypad scanner. Drives one column low at a time,
//                synchronizes the rows, builds a 16-bit hit map per scan,
//                classifies it and debounces it into key events which are
//                shifted into a 16-bit display value.
//  Optional    : KEYPAD_AUTOREPEAT_EN - auto-repeat of a held key.
//  Ports       : clk            system clock
//                rst_n          asynchronous active-low reset
//                row_n [3:0]    keypad rows, active-low, asynchronous
//                col_n [3:0]    column drive, active-low, one-hot-zero
//                clr            synchronous clear of val
//                key_valid      one-cycle pulse per accepted key event
//                key_code [3:0] last accepted key, held between events
//                key_held       debounced key is down
//                val [15:0]     digit shift register, newest in [3:0]
//  Revision    : 1.0 - initial release
// ============================================================================
module hex_keypad_scanner
    import hex_keypad_pkg::*;
#(
    parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
    parameter int DEBOUNCE_SCANS = DEF_DEBOUNCE_SCANS,
    parameter int REPEAT_DELAY   = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD  = DEF_REPEAT_PERIOD
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  row_n,
    output logic [3:0]  col_n,
    input  logic        clr,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic        key_held,
    output logic [15:0] val
);

    localparam int            SW          = $clog2(SETTLE_CYCLES);
    localparam logic [SW-1:0] C_SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

    logic [3:0]    row_s1_q, row_s2_q;
    logic [SW-1:0] settle_q;
    logic [1:0]    col_idx_q;
    logic [3:0]    col_n_q;
    logic [15:0]   hit_q;         // active-high, bit index {row, col}
    logic          strobe_q;      // high in the evaluation cycle
    logic [15:0]   val_q;
    logic          w_capture;
    logic [1:0]    w_hits;        // saturating hit count: 0, 1, 2+
    logic [3:0]    w_idx;
    logic [1:0]    w_res;
    logic          w_key_valid;
    logic [3:0]    w_key_code;

    assign w_capture = (settle_q == C_SETTLE_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_s1_q  <= 4'hF;
            row_s2_q  <= 4'hF;
            settle_q  <= '0;
            col_idx_q <= 2'd0;
            col_n_q   <= 4'b1110;
            hit_q     <= 16'h0000;
            strobe_q  <= 1'b0;
        end else begin
            row_s1_q <= row_n;
            row_s2_q <= row_s1_q;
            strobe_q <= w_capture && (col_idx_q == 2'd3);
            if (w_capture) begin
                settle_q  <= '0;
                col_idx_q <= col_idx_q + 2'd1;
                col_n_q   <= {col_n_q[2:0], col_n_q[3]};
                for (int r = 0; r < 4; r++) begin
                    hit_q[{2'(r), col_idx_q}] <= ~row_s2_q[r];
                end
            end else begin
                settle_q <= settle_q + SW'(1);
            end
        end
    end

    // Every slice is rewritten each scan, so in the evaluation cycle the
    // map holds exactly the scan just completed.
    always_comb begin
        w_hits = 2'd0;
        w_idx  = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (hit_q[i]) begin
                if (w_hits != 2'd2) begin
                    w_hits = w_hits + 2'd1;
                end
                w_idx = 4'(i);
            end
        end
        case (w_hits)
            2'd0:    w_res = SCAN_NONE;
            2'd1:    w_res = SCAN_SINGLE;
            default: w_res = SCAN_MULTI;
        endcase
    end

    keypad_debounce #(
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS),
        .REPEAT_DELAY   (REPEAT_DELAY),
        .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_debounce (
        .clk         (clk),
        .rst_n       (rst_n),
        .strobe_i    (strobe_q),
        .res_i       (w_res),
        .key_i       (key_lookup(w_idx)),
        .key_valid_o (w_key_valid),
        .key_code_o  (w_key_code),
        .key_held_o  (key_held)
    );

    // clr overrides the shift; the event itself is still reported.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            val_q <= 16'h0000;
        end else if (clr) begin
            val_q <= 16'h0000;
        end else if (w_key_valid) begin
            val_q <= {val_q[11:0], w_key_code};
        end
    end

    assign col_n     = col_n_q;
    assign key_valid = w_key_valid;
    assign key_code  = w_key_code;
    assign val       = val_q;

endmodule
`default_nettype wire

// File: tb/tb_hex_keypad_scanner.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_hex_keypad_scanner
//  Description : Self-checking bench for hex_keypad_scanner. A physical
//                keypad model turns a set of pressed keys into row levels;
//                a scan-level reference model predicts events, key_held,
//                key_code and val.
//  Optional    : KEYPAD_AUTOREPEAT_EN changes the expected event stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hex_keypad_scanner;

    localparam int S    = 8;
    localparam int DB   = 4;
    localparam int RD   = 8;
    localparam int RP   = 2;
    localparam int SCAN = 4 * S;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_held;
    logic [15:0] val;
    logic [15:0] pressed = 16'h0000;   // bit {row,col} = key is down

    int checks = 0;
    int failures = 0;
    int n_obs = 0;

    // Reference model state
    int          m_mode;     // 0 up, 1 confirming press, 2 down, 3 confirming release
    int          m_cand, m_cnt, m_code, m_rpt;
    logic [15:0] m_val;
    bit          pend_valid, pend_held;

    int layout [4][4] = '{'{1, 2, 3, 10}, '{4, 5, 6, 11}, '{7, 8, 9, 12}, '{0, 15, 14, 13}};

    hex_keypad_scanner #(
        .SETTLE_CYCLES  (S),
        .DEBOUNCE_SCANS (DB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .row_n     (row_n),
        .col_n     (col_n),
        .clr       (clr),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_held  (key_held),
        .val       (val)
    );

    always #5 clk = ~clk;

    // A pressed key shorts its row to its column; rows idle high.
    always_comb begin
        row_n = 4'hF;
        for (int r = 0; r < 4; r++) begin
            if (|(pressed[r*4 +: 4] & ~col_n)) row_n[r] = 1'b0;
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] mask_of(input int hex);
        logic [15:0] m = 16'h0000;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (layout[r][c] == hex) m[r*4 + c] = 1'b1;
        return m;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_cand = 0; m_cnt = 0; m_code = 0; m_rpt = 0;
        m_val = 16'h0000; pend_valid = 0; pend_held = 0;
    endtask

    // One full scan seen with the given set of keys down.
    task automatic model_scan(input logic [15:0] mask);
        int k = -1;
        bit ev = 0;
        if ($countones(mask) == 1)
            for (int i = 0; i < 16; i++) if (mask[i]) k = layout[i/4][i%4];
        case (m_mode)
            0: if (k >= 0) begin m_mode = 1; m_cand = k; m_cnt = 1; end
            1: begin
                if (k == m_cand) begin
                    m_cnt++;
                    if (m_cnt >= DB) begin m_mode = 2; ev = 1; m_code = m_cand; m_rpt = 0; end
                end else if (k >= 0) begin m_cand = k; m_cnt = 1; end
                else m_mode = 0;
            end
            2: begin
                if (k == m_cand) begin
`ifdef KEYPAD_AUTOREPEAT_EN
                    m_rpt++;
                    if (m_rpt == RD || (m_rpt > RD && (m_rpt - RD) % RP == 0)) ev = 1;
`endif
                end else begin m_mode = 3; m_cnt = 1; end
            end
            default: begin
                if (k == m_cand) m_mode = 2;
                else if (k >= 0) begin m_mode = 1; m_cand = k; m_cnt = 1; end
                else begin m_cnt++; if (m_cnt >= DB) m_mode = 0; end
            end
        endcase
        pend_valid = ev;
        pend_held  = (m_mode == 2 || m_mode == 3);
    endtask

    // Hold 'mask' for one full scan; clr is pulsed in cycle clr_at (0 = none).
    // Entry and exit are on the falling edge of the first cycle of a scan.
    task automatic scan(input logic [15:0] mask, input int clr_at);
        logic [3:0] exp_col;
        pressed = mask;
        for (int t = 1; t <= SCAN; t++) begin
            @(negedge clk);
            exp_col = ~(4'b0001 << ((t / S) % 4));
            checks++;
            if (col_n !== exp_col) begin
                failures++; $display("FAIL col_n t=%0d got=%b exp=%b", t, col_n, exp_col);
            end
            checks++;
            if (key_valid !== ((t == 1) ? pend_valid : 1'b0)) begin
                failures++; $display("FAIL key_valid t=%0d got=%b exp=%b", t, key_valid, (t == 1) && pend_valid);
            end
            checks++;
            if (key_held !== pend_held) begin
                failures++; $display("FAIL key_held t=%0d got=%b exp=%b", t, key_held, pend_held);
            end
            checks++;
            if (key_code !== 4'(m_code)) begin
                failures++; $display("FAIL key_code t=%0d got=%h exp=%h", t, key_code, 4'(m_code));
            end
            checks++;
            if (val !== m_val) begin
                failures++; $display("FAIL val t=%0d got=%h exp=%h", t, val, m_val);
            end
            if (key_valid === 1'b1) n_obs++;
            if (t == 1 && pend_valid) m_val = {m_val[11:0], 4'(m_code)};
            if (t == clr_at) begin clr = 1'b1; m_val = 16'h0000; end
            else clr = 1'b0;
        end
        model_scan(mask);
    endtask

    task automatic scans(input logic [15:0] mask, input int n);
        for (int i = 0; i < n; i++) scan(mask, 0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (col_n !== 4'b1110) begin failures++; $display("FAIL rst_col got=%b exp=1110", col_n); end
        checks++; if (val !== 16'h0) begin failures++; $display("FAIL rst_val got=%h exp=0000", val); end
        checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", key_valid); end
        checks++; if (key_held !== 1'b0) begin failures++; $display("FAIL rst_held got=%b exp=0", key_held); end
        checks++; if (key_code !== 4'h0) begin failures++; $display("FAIL rst_code got=%h exp=0", key_code); end
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_single_press();
        n_obs = 0;
        scans(mask_of(5), 10);
        scans(16'h0, 6);
        checks++; if (n_obs != 1) begin failures++; $display("FAIL single_events got=%0d exp=1", n_obs); end
        checks++; if (val !== 16'h0005) begin failures++; $display("FAIL single_val got=%h exp=0005", val); end
        checks++; if (key_code !== 4'h5) begin failures++; $display("FAIL single_code got=%h exp=5", key_code); end
    endtask

    task automatic test_entry();
        int          digits [5] = '{1, 2, 3, 10, 15};
        logic [15:0] expv [5] = '{16'h0001, 16'h0012, 16'h0123, 16'h123A, 16'h23AF};
        scan(16'h0, 5);
        for (int i = 0; i < 5; i++) begin
            scans(mask_of(digits[i]), 5);
            scans(16'h0, 5);
            checks++;
            if (val !== expv[i]) begin failures++; $display("FAIL entry_val%0d got=%h exp=%h", i, val, expv[i]); end
        end
    endtask

    task automatic test_bounce();
        logic [15:0] k9 = mask_of(9);
        n_obs = 0;
        scan(k9, 0); scan(16'h0, 0); scan(k9, 0); scan(16'h0, 0);
        scans(k9, 6);
        scan(16'h0, 0); scan(k9, 0); scan(16'h0, 0); scan(k9, 0);
        scans(16'h0, 6);
        checks++; if (n_obs != 1) begin failures++; $display("FAIL bounce_events got=%0d exp=1", n_obs); end
        checks++; if (key_code !== 4'h9) begin failures++; $display("FAIL bounce_code got=%h exp=9", key_code); end
    endtask

    task automatic test_multi_rollover();
        logic [15:0] v0 = m_val;
        n_obs = 0;
        scans(mask_of(1) | mask_of(2), 6);
        scans(16'h0, 5);
        checks++; if (n_obs != 0) begin failures++; $display("FAIL multi_events got=%0d exp=0", n_obs); end
        checks++; if (val !== v0) begin failures++; $display("FAIL multi_val got=%h exp=%h", val, v0); end
        scans(mask_of(4), 6);
        scans(mask_of(7), 6);
        checks++; if (n_obs != 2) begin failures++; $display("FAIL roll_events got=%0d exp=2", n_obs); end
        checks++; if (key_code !== 4'h7) begin failures++; $display("FAIL roll_code got=%h exp=7", key_code); end
        scans(16'h0, 5);
    endtask

    task automatic test_clear();
        scans(mask_of(11), 4);
        scan(mask_of(11), 1);     // clr lands in the pulse cycle
        scan(mask_of(11), 0);
        checks++; if (val !== 16'h0000) begin failures++; $display("FAIL clr_val got=%h exp=0000", val); end
        checks++; if (key_code !== 4'hB) begin failures++; $display("FAIL clr_code got=%h exp=B", key_code); end
        scans(16'h0, 5);
    endtask

    task automatic test_autorepeat();
        int          exp_n;
        logic [15:0] exp_v;
`ifdef KEYPAD_AUTOREPEAT_EN
        exp_n = 3; exp_v = 16'h0CCC;
`else
        exp_n = 1; exp_v = 16'h000C;
`endif
        scan(16'h0, 7);
        n_obs = 0;
        scans(mask_of(12), 14);
        scans(16'h0, 5);
        checks++; if (n_obs != exp_n) begin failures++; $display("FAIL repeat_events got=%0d exp=%0d", n_obs, exp_n); end
        checks++; if (val !== exp_v) begin failures++; $display("FAIL repeat_val got=%h exp=%h", val, exp_v); end
    endtask

    task automatic test_random();
        logic [15:0] m;
        for (int seg = 0; seg < 40; seg++) begin
            int kind = $urandom_range(0, 9);
            if (kind <= 5) m = mask_of($urandom_range(0, 15));
            else if (kind <= 7) m = 16'h0;
            else m = mask_of($urandom_range(0, 7)) | mask_of($urandom_range(8, 15));
            scans(m, $urandom_range(1, 6));
        end
        scans(16'h0, 5);
    endtask

    task automatic test_reset_midscan();
        scans(mask_of(5), 2);
        pressed = mask_of(5);
        repeat (S + 3) @(negedge clk);
        pressed = 16'h0;
        test_reset();
        n_obs = 0;
        scans(16'h0, 6);
        checks++; if (n_obs != 0) begin failures++; $display("FAIL midreset_events got=%0d exp=0", n_obs); end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_press();
        test_entry();
        test_bounce();
        test_multi_rollover();
        test_clear();
        test_autorepeat();
        test_random();
        test_reset_midscan();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
